// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling 8N1 UART receiver.
// The line is double-synchronised and then sampled at the middle of every bit.
// Each good frame loads o_rx_data and pulses o_rx_done for one cycle.
// A low stop bit pulses o_frame_err once and leaves o_rx_data untouched.
module uart_rx #(
  parameter int unsigned CLKS_PER_TICK = 163,
  parameter int unsigned DATA_BITS     = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err
);

  localparam int unsigned DIV_W  = $clog2(CLKS_PER_TICK);
  localparam int unsigned BCNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t               state;
  state_t               state_n;
  logic                 rx_meta;
  logic                 rx_s;
  logic [DIV_W-1:0]     div;
  logic [3:0]           tcnt;
  logic [BCNT_W-1:0]    bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 run;
  logic                 tick;
  logic                 sample_bit;
  logic                 done_n;
  logic                 err_n;

  // The divider only runs while a frame is being timed.
  assign run  = (state == S_START) || (state == S_DATA) || (state == S_STOP);
  assign tick = run && (div == DIV_W'(CLKS_PER_TICK - 1));

  // State register.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic and per-cycle strobes.
  always_comb begin
    state_n    = state;
    sample_bit = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_n = S_START;
        end
      end
      S_START: begin
        // Re-check the line at the middle of the start bit to reject glitches.
        if (tick && (tcnt == 4'd7)) begin
          state_n = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick && (tcnt == 4'd15)) begin
          sample_bit = 1'b1;
          if (bcnt == BCNT_W'(DATA_BITS - 1)) begin
            state_n = S_STOP;
          end
        end
      end
      S_STOP: begin
        // Leaving at mid-stop gives half a bit of margin for the next start bit.
        if (tick && (tcnt == 4'd15)) begin
          if (rx_s) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Synchroniser, bit timing counters, shift register and registered outputs.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      div         <= '0;
      tcnt        <= '0;
      bcnt        <= '0;
      shreg       <= '0;
      o_rx_data   <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;

      if (!run || tick) begin
        div <= '0;
      end else begin
        div <= div + DIV_W'(1);
      end

      if (state_n != state) begin
        tcnt <= '0;
      end else if (tick) begin
        tcnt <= tcnt + 4'd1;
      end

      if (state != S_DATA) begin
        bcnt <= '0;
      end else if (sample_bit) begin
        bcnt <= bcnt + BCNT_W'(1);
      end

      if (sample_bit) begin
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      end

      o_rx_done   <= done_n;
      o_frame_err <= err_n;
      if (done_n) begin
        o_rx_data <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives uart_rx from a behavioural serial line model and compares
// received bytes / error strobes with the outcome each frame should have.
module tb_uart_rx;

  localparam int CPT = 4;
  localparam int NB  = 8;
  localparam int BIT = 16 * CPT;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       done;
  logic       ferr;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_TICK(CPT), .DATA_BITS(NB)) dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_rx       (rx),
    .o_rx_data  (rx_data),
    .o_rx_done  (done),
    .o_frame_err(ferr)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed strobes.
  logic [7:0]  done_q[$];
  int unsigned done_cyc[$];
  int          err_cnt    = 0;
  bit          shape_bad  = 1'b0;
  logic        prev_done  = 1'b0;
  logic        prev_err   = 1'b0;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_q.push_back(rx_data);
      done_cyc.push_back(cyc);
    end
    if (ferr === 1'b1) err_cnt++;
    if (done === 1'b1 && ferr === 1'b1) shape_bad = 1'b1;
    if ((done === 1'b1 && prev_done === 1'b1) || (ferr === 1'b1 && prev_err === 1'b1))
      shape_bad = 1'b1;
    prev_done = done;
    prev_err  = ferr;
  end

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: last byte that should be showing on o_rx_data.
  logic [7:0] last_good = 8'h00;

  typedef struct {
    bit         glitch;
    logic [7:0] data;
    bit         stop;
    int         period;
    int         extra_low;
    int         gap;
    bit         exp_done;
    logic [7:0] exp_data;
    bit         exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic clear_obs();
    done_q.delete();
    done_cyc.delete();
    err_cnt   = 0;
    shape_bad = 1'b0;
  endtask

  task automatic hold(input logic lvl, input int n);
    rx = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int p);
    hold(1'b0, p);
    for (int i = 0; i < NB; i++) hold(d[i], p);
    hold(stop, p);
  endtask

  task automatic check_outcome(input string tag, input bit exp_done, input logic [7:0] exp_data,
                               input bit exp_err);
    check({tag, ":done_count"}, 32'(done_q.size()), 32'(exp_done));
    if (exp_done && done_q.size() > 0) check({tag, ":data"}, 32'(done_q[0]), 32'(exp_data));
    check({tag, ":err_count"}, 32'(err_cnt), 32'(exp_err));
    check({tag, ":rx_data_held"}, 32'(rx_data), 32'(last_good));
    check({tag, ":strobe_shape"}, 32'(shape_bad), 32'(0));
  endtask

  task automatic play(input vec_t v, input string tag, output int unsigned t0);
    clear_obs();
    t0 = cyc;
    if (v.glitch) begin
      hold(1'b0, 20);
      hold(1'b1, 100);
    end else begin
      send_frame(v.data, v.stop, v.period);
      if (v.extra_low > 0) hold(1'b0, v.extra_low);
      hold(1'b1, v.gap);
    end
    if (v.exp_done) last_good = v.exp_data;
    check_outcome(tag, v.exp_done, v.exp_data, v.exp_err);
  endtask

  initial begin
    int unsigned t0;
    int          lat;
    vec_t        v;

    //                glitch data   stop period xlow gap  done data   err
    vecs[0] = '{1'b0, 8'h81, 1'b1, 64, 0,   0,  1'b1, 8'h81, 1'b0};
    vecs[1] = '{1'b0, 8'h7E, 1'b1, 64, 0,   0,  1'b1, 8'h7E, 1'b0};
    vecs[2] = '{1'b0, 8'h08, 1'b1, 64, 0,   40, 1'b1, 8'h08, 1'b0};
    vecs[3] = '{1'b1, 8'h00, 1'b1, 64, 0,   0,  1'b0, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 8'hA5, 1'b1, 64, 0,   20, 1'b1, 8'hA5, 1'b0};
    vecs[5] = '{1'b0, 8'h3C, 1'b0, 64, 192, 20, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{1'b0, 8'h55, 1'b1, 64, 0,   20, 1'b1, 8'h55, 1'b0};
    vecs[7] = '{1'b0, 8'hC3, 1'b1, 62, 0,   20, 1'b1, 8'hC3, 1'b0};
    vecs[8] = '{1'b0, 8'hC3, 1'b1, 66, 0,   20, 1'b1, 8'hC3, 1'b0};

    // Reset with a toggling line.
    repeat (3) begin
      @(negedge clk);
      rx = ~rx;
    end
    check("reset:rx_data", 32'(rx_data), 32'(0));
    check("reset:done", 32'(done), 32'(0));
    check("reset:frame_err", 32'(ferr), 32'(0));
    rx    = 1'b1;
    rst_n = 1'b1;
    clear_obs();
    repeat (1000) @(negedge clk);
    check("idle:done_count", 32'(done_q.size()), 32'(0));
    check("idle:err_count", 32'(err_cnt), 32'(0));

    // Directed vectors.
    for (int i = 0; i < 9; i++) begin
      play(vecs[i], $sformatf("vec%0d", i), t0);
      if (i == 0) begin
        lat = (done_cyc.size() > 0) ? int'(done_cyc[0] - t0) : -1;
        n_total++;
        if (lat >= 610 && lat <= 612) n_pass++;
        else $display("FAIL first_latency: got %0d cycles, expected 611 +-1", lat);
      end
    end

    // Reset in the middle of data bit 4 of 0xFF.
    clear_obs();
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(1'b1, BIT);
    hold(1'b1, 20);
    rst_n = 1'b0;
    hold(1'b1, 3);
    check("midreset:rx_data", 32'(rx_data), 32'(0));
    check("midreset:done", 32'(done), 32'(0));
    check("midreset:frame_err", 32'(ferr), 32'(0));
    rst_n     = 1'b1;
    last_good = 8'h00;
    hold(1'b1, 200);
    check("midreset:done_count", 32'(done_q.size()), 32'(0));
    check("midreset:err_count", 32'(err_cnt), 32'(0));
    v = '{1'b0, 8'h12, 1'b1, 64, 0, 20, 1'b1, 8'h12, 1'b0};
    play(v, "after_reset", t0);

    // Randomised frames with baud skew, random gaps and occasional framing errors.
    for (int k = 0; k < 24; k++) begin
      v.glitch    = 1'b0;
      v.data      = 8'($urandom);
      v.stop      = ($urandom_range(0, 5) != 0);
      v.period    = int'($urandom_range(62, 66));
      v.extra_low = v.stop ? 0 : int'($urandom_range(0, 128));
      v.gap       = v.stop ? int'($urandom_range(0, 30)) : int'($urandom_range(10, 30));
      v.exp_done  = v.stop;
      v.exp_data  = v.data;
      v.exp_err   = !v.stop;
      play(v, $sformatf("rand%0d", k), t0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver that sits directly upstream of the command interface. It oversamples the asynchronous `i_rx` line at 16× baud, deframes 8N1 characters LSB-first, and delivers each byte on `o_rx_data` with a one-cycle `o_rx_done` strobe. That byte/strobe pair is the interface's `i_rx_data` / `i_rx_done` input. Framing errors are flagged separately and never produce a data strobe.

## Interface
- `CLKS_PER_TICK`, 163 — system clocks per 16× oversample tick (50 MHz / (19200·16)); must be ≥ 2
- `DATA_BITS`, 8 — data bits per frame
- `i_clock`  in  1  system clock, all logic on rising edge
- `i_reset`  in  1  synchronous, active-low reset (0 = reset)
- `i_rx`  in  1  asynchronous serial line, idle high
- `o_rx_data`  out  DATA_BITS  last correctly framed byte; held until the next good frame
- `o_rx_done`  out  1  one-cycle pulse, `o_rx_data` valid in the same cycle
- `o_frame_err`  out  1  one-cycle pulse when the stop bit samples low

## Operation
- Input: two-flop synchronizer on `i_rx` gives `rx_s`. All decisions use `rx_s`.
- Divisor counter `div`, 0..CLKS_PER_TICK-1:
  - held at 0 in IDLE and WAIT_HIGH, free-runs otherwise
  - `tick` asserts when `div == CLKS_PER_TICK-1`, then `div` wraps to 0
- Tick counter `tcnt` (4 bits) counts ticks within a bit and is cleared on every state change. Bit counter `bcnt` counts received data bits.
- FSM:
  - **IDLE**: when `rx_s == 0`, go to START.
  - **START**: on the 8th tick (mid start bit), sample `rx_s`.
    - 0 → DATA.
    - 1 → IDLE (glitch rejected, no outputs).
  - **DATA**: on each 16th tick, shift `rx_s` into the MSB of `shreg` (right shift, LSB-first).
    - After DATA_BITS samples → STOP.
  - **STOP**: on the 16th tick, sample `rx_s`.
    - 1 → load `o_rx_data <= shreg`, pulse `o_rx_done`, go to IDLE.
    - 0 → pulse `o_frame_err`, leave `o_rx_data` unchanged, go to WAIT_HIGH.
  - **WAIT_HIGH**: stay until `rx_s == 1`, then go to IDLE. A held-low break yields exactly one `o_frame_err`.
- Reset (`i_reset == 0` at a clock edge), at any point including mid-frame:
  - state = IDLE; `div`, `tcnt`, `bcnt`, `shreg` = 0
  - `o_rx_data` = 0, `o_rx_done` = 0, `o_frame_err` = 0
  - synchronizer flops = 1 (idle line)
  - the partial frame is discarded with no strobe.
- `o_rx_done` and `o_frame_err` are never asserted together. Each is high for exactly one cycle per frame.

## Timing
- Synchronizer latency: 2 cycles. IDLE→START occurs on the 3rd rising edge after `i_rx` falls (edge 0 = first edge seeing the low).
- Bit period = 16·CLKS_PER_TICK clocks. Sample points: start bit at 8 ticks, data bits at +16 ticks each, stop bit at +16.
- Frame latency from the `i_rx` falling edge to `o_rx_done` high = (8 + 16·DATA_BITS + 16)·CLKS_PER_TICK + 3 cycles, ±1.
  - CLKS_PER_TICK = 4, 8 bits: 611 ±1 cycles.
- `o_rx_done` is registered and asserts the cycle after the stop-bit sample edge.
- Back-to-back frames: a start bit beginning immediately after the stop bit's midpoint must be accepted. The FSM returns to IDLE at mid-stop, leaving half a bit of margin.
- Tolerates ±3 % baud mismatch, since sampling is at mid-bit.

## Test plan
Use CLKS_PER_TICK = 4 (bit period 64 clocks) and drive `i_rx` from a bench UART model.
- **Reset**: hold `i_reset = 0` for 3 cycles with `i_rx` toggling → all outputs 0, no strobes. Release with `i_rx = 1` → no activity for 1000 cycles.
- **Command sequence**: frames 0x81, 0x7E, 0x08, back-to-back with one stop bit each → three `o_rx_done` pulses, `o_rx_data` = 0x81, 0x7E, 0x08 in order, each pulse 1 cycle wide. The first pulse lands 611 ±1 cycles after the first falling edge.
- **Glitch rejection**: `i_rx` low for 20 clocks, then high → FSM returns to IDLE, no `o_rx_done`, no `o_frame_err`. A following valid 0xA5 frame is received correctly.
- **Framing error**: send 0x3C with stop bit = 0, then hold low for 3 bit times, then high → exactly one `o_frame_err`, no `o_rx_done`, `o_rx_data` keeps its previous value. The next 0x55 frame is received correctly.
- **Reset mid-frame**: assert reset during data bit 4 of 0xFF → outputs 0, no strobe. A fresh 0x12 frame after release is received as 0x12.
- **Baud skew**: send 0xC3 at bit periods of 62 and 66 clocks → received correctly both times.
